seg7_mux_driver: RTL and testbench
==================================

Name: seg7_mux_driver

Overview:
Parametrised, time-multiplexed driver for an N-digit common-anode/cathode 7-segment display. It captures a packed 4-bit-per-digit value word on a load strobe and decodes each nibble to full hex glyphs 0-F. It scans one digit per refresh slot, with an anti-ghosting blank interval, optional leading-zero blanking and per-digit decimal points. It sits between the ALU result/status path and the board display pins, replacing per-digit combinational decoders.

Parameters:
N_DIGITS, 4, number of digits scanned (legal 1..8)
REFRESH_DIV, 50000, clk cycles per digit slot (must be > BLANK_CYCLES+1)
BLANK_CYCLES, 16, cycles at start of each slot with all anodes inactive
SEG_ACTIVE_LOW, 1, 1: segment lit = 0; 0: segment lit = 1
AN_ACTIVE_LOW, 1, 1: anode enabled = 0; 0: anode enabled = 1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; 0 freezes scan and blanks display
load  in  1  capture strobe for data_in/dp_in
data_in  in  4*N_DIGITS  packed nibbles, digit 0 = bits [3:0] (least significant)
dp_in  in  N_DIGITS  decimal point request per digit
lz_blank  in  1  1 = suppress leading zeros (sampled live, not on load)
seg  out  7  segments, seg[6]=a ... seg[0]=g, polarity per SEG_ACTIVE_LOW
dp  out  1  decimal point, same polarity as seg
an  out  N_DIGITS  digit enables, one-hot when active, polarity per AN_ACTIVE_LOW
digit_idx  out  clog2(N_DIGITS) (min 1)  index of digit currently driven

Behaviour:
- Reset: as stated under Ports, rst_n is asynchronous active-low. While asserted: shadow data/dp = 0, slot counter = 0, digit_idx = 0, an all inactive, seg and dp all unlit.
- Shadow capture: load=1 at edge t copies data_in/dp_in into shadow registers. Because outputs are registered from the shadow, the new glyph appears on seg at edge t+1 when that digit is being driven.
- Slot counter: counts 0..REFRESH_DIV-1 while en=1. At terminal count it wraps to 0 and digit_idx increments, wrapping N_DIGITS-1 -> 0. With N_DIGITS=1, digit_idx stays 0.
- Blank window: when counter < BLANK_CYCLES, an is all inactive and seg/dp are unlit. Otherwise an enables digit_idx only.
- Output register: seg, dp and an are all registered. They reflect the counter/digit_idx state present before the edge, giving 1 cycle latency and no combinational path from inputs to pins.
- Decode, in active-low form before polarity is applied:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - SEG_ACTIVE_LOW=0 inverts all segment bits and dp.
- Leading-zero blanking (lz_blank=1): a digit is unlit if its nibble is 0 and every more-significant nibble is 0. Digit 0 is never blanked, so value 0 shows "0". The anode stays enabled for a blanked digit. dp still honours dp_in for a blanked digit.
- en=0: counter and digit_idx hold their values, and outputs go unlit/inactive on the next edge. load is still honoured. When en returns to 1, scanning resumes from the held count.
- load coincident with terminal count: both take effect. The next slot decodes from the new shadow value.
- Reset mid-slot: immediate return to reset values. The first slot after release starts with a full blank window.

Decomposition:
- Package seg7_pkg holds:
  - the 16 active-low glyph constants plus SEG_OFF=7'b1111111;
  - a function to apply polarity;
  - a function computing the index width from N_DIGITS.
- Sub-module seg7_hex_decode: purely combinational nibble -> active-low 7-bit glyph, instantiated once on the selected nibble.
- Top level: counter, index, shadow registers, LZ mask, output registers.

Test Plan:
- Reset: hold rst_n=0 mid-scan -> an=4'b1111, seg=7'h7F, dp=1, digit_idx=0 immediately, without waiting for a clock edge. Release -> first BLANK_CYCLES cycles stay blank.
- Full scan, REFRESH_DIV=8, BLANK_CYCLES=2: load data_in=16'h1A2F -> digit_idx runs 0,1,2,3,0 every 8 cycles. Per digit, seg shows F=0111000, 2=0010010, A=0001000, 1=1001111, with an=1110,1101,1011,0111 during cycles 2..7 of each slot.
- Leading zeros: data_in=16'h0050, lz_blank=1 -> digits 3,2 unlit, digit 1 = 0100100, digit 0 = 0000001. With lz_blank=0 digits 3,2 show 0000001. For data_in=0, only digit 0 shows 0000001.
- Decimal point and polarity: dp_in=4'b0100, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0 -> dp=1 only in digit 2's slot, an one-hot high, seg bits inverted (e.g. 8 -> 1111111).
- Enable freeze and load at wrap: deassert en at count 5 of digit 1 -> outputs blank next cycle and counter holds at 5. Pulse load=16'h9999 at the terminal-count cycle after re-enable -> the next slot shows 0000100.
- Exhaustive decode: load each nibble 0..F into digit 0 with N_DIGITS=1 -> seg matches the package table for all 16 values.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph table, polarity helpers and width helpers for the multiplexed
// 7-segment driver. Glyphs are active-low, seg[6]=a ... seg[0]=g.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [6:0] GLYPH_C = 7'b0110001;
  localparam logic [6:0] GLYPH_D = 7'b1000010;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_F = 7'b0111000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // What the output stage drives during the current cycle.
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_BLANK,
    PH_LIT
  } phase_e;

  function automatic logic [6:0] apply_seg_pol(input logic [6:0] glyph_al,
                                               input bit active_low);
    return active_low ? glyph_al : ~glyph_al;
  endfunction

  function automatic logic apply_dp_pol(input logic lit, input bit active_low);
    return active_low ? ~lit : lit;
  endfunction

  function automatic int idx_width(input int n_digits);
    return (n_digits <= 1) ? 1 : $clog2(n_digits);
  endfunction

  function automatic int cnt_width(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low hex glyph (0-9, A, b, C, d, E, F).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = SEG_OFF;
    case (nibble_i)
      4'h0: glyph_o = GLYPH_0;
      4'h1: glyph_o = GLYPH_1;
      4'h2: glyph_o = GLYPH_2;
      4'h3: glyph_o = GLYPH_3;
      4'h4: glyph_o = GLYPH_4;
      4'h5: glyph_o = GLYPH_5;
      4'h6: glyph_o = GLYPH_6;
      4'h7: glyph_o = GLYPH_7;
      4'h8: glyph_o = GLYPH_8;
      4'h9: glyph_o = GLYPH_9;
      4'hA: glyph_o = GLYPH_A;
      4'hB: glyph_o = GLYPH_B;
      4'hC: glyph_o = GLYPH_C;
      4'hD: glyph_o = GLYPH_D;
      4'hE: glyph_o = GLYPH_E;
      4'hF: glyph_o = GLYPH_F;
      default: glyph_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit hex display driver: one digit per refresh slot,
// blank window at slot start, leading-zero blanking, per-digit decimal points.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic                             load,
  input  logic [4*N_DIGITS-1:0]            data_in,
  input  logic [N_DIGITS-1:0]              dp_in,
  input  logic                             lz_blank,
  output logic [6:0]                       seg,
  output logic                             dp,
  output logic [N_DIGITS-1:0]              an,
  output logic [idx_width(N_DIGITS)-1:0]   digit_idx
);

  localparam int IDX_W = idx_width(N_DIGITS);
  localparam int CNT_W = cnt_width(REFRESH_DIV);

  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]    CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [6:0]          SEG_UNLIT = apply_seg_pol(SEG_OFF, SEG_ACTIVE_LOW);
  localparam logic                DP_UNLIT  = apply_dp_pol(1'b0, SEG_ACTIVE_LOW);
  localparam logic [N_DIGITS-1:0] AN_OFF    = {N_DIGITS{AN_ACTIVE_LOW}};

  logic [4*N_DIGITS-1:0] shadow_q;
  logic [N_DIGITS-1:0]   dp_shadow_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;

  logic [3:0]            nib_sel;
  logic                  dp_sel;
  logic [N_DIGITS-1:0]   an_sel;
  logic [N_DIGITS-1:0]   lz_mask;
  logic                  digit_blank;
  logic [6:0]            glyph_al;
  phase_e                phase;

  // Slot timer and digit index; both freeze while the scan is disabled.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    nib_sel = 4'h0;
    dp_sel  = 1'b0;
    an_sel  = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_sel   = shadow_q[4*i +: 4];
        dp_sel    = dp_shadow_q[i];
        an_sel[i] = 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every more-significant nibble are 0;
  // digit 0 is excluded so an all-zero value still reads "0".
  always_comb begin
    lz_mask = '0;
    for (int i = 1; i < N_DIGITS; i++) begin
      lz_mask[i] = 1'b1;
      for (int j = i; j < N_DIGITS; j++) begin
        if (shadow_q[4*j +: 4] != 4'h0) lz_mask[i] = 1'b0;
      end
    end
  end

  assign digit_blank = lz_blank & (|(lz_mask & an_sel));

  seg7_hex_decode u_dec (
    .nibble_i (nib_sel),
    .glyph_o  (glyph_al)
  );

  always_comb begin
    if (!en)                    phase = PH_IDLE;
    else if (cnt_q < CNT_BLANK) phase = PH_BLANK;
    else                        phase = PH_LIT;
  end

  // Blanked digits keep their anode and decimal point; only segments go dark.
  always_comb begin
    seg_d = SEG_UNLIT;
    dp_d  = DP_UNLIT;
    an_d  = AN_OFF;
    case (phase)
      PH_LIT: begin
        seg_d = apply_seg_pol(digit_blank ? SEG_OFF : glyph_al, SEG_ACTIVE_LOW);
        dp_d  = apply_dp_pol(dp_sel, SEG_ACTIVE_LOW);
        an_d  = AN_ACTIVE_LOW ? ~an_sel : an_sel;
      end
      default: begin
        seg_d = SEG_UNLIT;
        dp_d  = DP_UNLIT;
        an_d  = AN_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      dp_shadow_q <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      seg_q       <= SEG_UNLIT;
      dp_q        <= DP_UNLIT;
      an_q        <= AN_OFF;
    end else begin
      if (load) begin
        shadow_q    <= data_in;
        dp_shadow_q <= dp_in;
      end
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign an        = an_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Self-checking bench: three driver instances (active-low 4-digit, active-high
// 4-digit, single digit) share stimulus and are checked every cycle.
module tb_seg7_mux_driver;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
    logic [2:0] idx;
  } exp_t;

  typedef struct {
    int          n;
    int          blank;
    int          div;
    bit          sl;
    bit          al;
    int          cnt;
    int          idx;
    logic [31:0] shadow;
    logic [7:0]  dpsh;
  } model_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, load, lz;
  logic [31:0] data;
  logic [7:0]  dpv;

  logic [6:0] seg0, seg1, seg2;
  logic       dpo0, dpo1, dpo2;
  logic [3:0] an0, an1;
  logic [0:0] an2;
  logic [1:0] idx0, idx1;
  logic [0:0] idx2;

  int     errors = 0;
  int     checks = 0;
  exp_t   sb[$];
  model_t m[3];
  logic [6:0] glyph_tbl [16];

  always #5 clk = ~clk;

  seg7_mux_driver #(.N_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
                    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data_in(data[15:0]),
    .dp_in(dpv[3:0]), .lz_blank(lz), .seg(seg0), .dp(dpo0), .an(an0), .digit_idx(idx0));

  seg7_mux_driver #(.N_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
                    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data_in(data[15:0]),
    .dp_in(dpv[3:0]), .lz_blank(lz), .seg(seg1), .dp(dpo1), .an(an1), .digit_idx(idx1));

  seg7_mux_driver #(.N_DIGITS(1), .REFRESH_DIV(4), .BLANK_CYCLES(1),
                    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data_in(data[3:0]),
    .dp_in(dpv[0:0]), .lz_blank(lz), .seg(seg2), .dp(dpo2), .an(an2), .digit_idx(idx2));

  function automatic exp_t observed(int k);
    exp_t o;
    o = '0;
    case (k)
      0: begin o.seg = seg0; o.dp = dpo0; o.an = {4'b0, an0}; o.idx = {1'b0, idx0}; end
      1: begin o.seg = seg1; o.dp = dpo1; o.an = {4'b0, an1}; o.idx = {1'b0, idx1}; end
      default: begin o.seg = seg2; o.dp = dpo2; o.an = {7'b0, an2}; o.idx = {2'b0, idx2}; end
    endcase
    return o;
  endfunction

  // Expected pins after the next edge, from the slot state before that edge.
  function automatic exp_t model_out(model_t s, logic en_v, logic lz_v);
    exp_t       e;
    logic [6:0] g;
    logic       lit_dp;
    logic [7:0] on;
    logic [7:0] nmask;
    logic       zero_run;
    logic [3:0] nib;
    g      = 7'b1111111;
    lit_dp = 1'b0;
    on     = 8'h00;
    nmask  = 8'((16'd1 << s.n) - 16'd1);
    if (en_v && s.cnt >= s.blank) begin
      nib      = s.shadow[s.idx*4 +: 4];
      zero_run = 1'b1;
      for (int j = s.idx; j < s.n; j++)
        if (s.shadow[j*4 +: 4] != 4'h0) zero_run = 1'b0;
      g      = (lz_v && s.idx != 0 && zero_run) ? 7'b1111111 : glyph_tbl[nib];
      lit_dp = s.dpsh[s.idx];
      on     = 8'h01 << s.idx;
    end
    e.seg = s.sl ? g : ~g;
    e.dp  = s.sl ? ~lit_dp : lit_dp;
    e.an  = s.al ? (~on & nmask) : on;
    e.idx = 3'd0;
    return e;
  endfunction

  task automatic model_reset(int k);
    m[k].cnt    = 0;
    m[k].idx    = 0;
    m[k].shadow = 32'h0;
    m[k].dpsh   = 8'h0;
  endtask

  task automatic predict();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        model_reset(k);
        e = model_out(m[k], 1'b0, lz);
      end else begin
        e = model_out(m[k], en, lz);
        if (load) begin
          m[k].shadow = data & 32'((64'd1 << (m[k].n * 4)) - 64'd1);
          m[k].dpsh   = dpv & 8'((16'd1 << m[k].n) - 16'd1);
        end
        if (en) begin
          if (m[k].cnt == m[k].div - 1) begin
            m[k].cnt = 0;
            m[k].idx = (m[k].idx == m[k].n - 1) ? 0 : m[k].idx + 1;
          end else begin
            m[k].cnt = m[k].cnt + 1;
          end
        end
      end
      e.idx = 3'(m[k].idx);
      sb.push_back(e);
    end
  endtask

  task automatic compare_all(string tag);
    exp_t e;
    exp_t o;
    for (int k = 0; k < 3; k++) begin
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL %s u%0d scoreboard empty", tag, k);
      end else begin
        e = sb.pop_front();
        o = observed(k);
        checks++;
        assert (o === e) else begin
          errors++;
          $error("FAIL %s u%0d observed seg=%b dp=%b an=%b idx=%0d expected seg=%b dp=%b an=%b idx=%0d",
                 tag, k, o.seg, o.dp, o.an, o.idx, e.seg, e.dp, e.an, e.idx);
        end
      end
    end
  endtask

  task automatic step(string tag);
    predict();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic run(string tag, int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_load(string tag, logic [31:0] d, logic [7:0] p);
    data = d;
    dpv  = p;
    load = 1'b1;
    step(tag);
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    glyph_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    m[0] = '{n:4, blank:2, div:8, sl:1'b1, al:1'b1, cnt:0, idx:0, shadow:32'h0, dpsh:8'h0};
    m[1] = '{n:4, blank:2, div:8, sl:1'b0, al:1'b0, cnt:0, idx:0, shadow:32'h0, dpsh:8'h0};
    m[2] = '{n:1, blank:1, div:4, sl:1'b1, al:1'b1, cnt:0, idx:0, shadow:32'h0, dpsh:8'h0};

    rst_n = 1'b0; en = 1'b0; load = 1'b0; lz = 1'b0; data = 32'h0; dpv = 8'h0;
    run("reset", 3);

    // Full scan of 1A2F, four slots plus wrap back to digit 0.
    rst_n = 1'b1;
    en    = 1'b1;
    do_load("load_1A2F", 32'h1A2F, 8'h00);
    run("scan_1A2F", 36);

    // Leading-zero blanking, on and off, then all-zero value.
    lz = 1'b1;
    do_load("load_0050", 32'h0050, 8'h00);
    run("lz_on_0050", 32);
    lz = 1'b0;
    run("lz_off_0050", 32);
    lz = 1'b1;
    do_load("load_0000", 32'h0000, 8'h00);
    run("lz_on_0000", 32);
    lz = 1'b0;

    // Decimal point on digit 2 and polarity with all-eights.
    do_load("load_8888_dp", 32'h8888, 8'h04);
    run("dp_8888", 32);
    lz = 1'b1;
    do_load("load_0000_dp", 32'h0000, 8'h04);
    run("lz_dp_blanked", 32);
    lz = 1'b0;

    // Freeze at count 5 of digit 1, resume, then load 9999 at terminal count.
    do_load("load_1234", 32'h1234, 8'h00);
    for (int i = 0; i < 64; i++) begin
      if (m[0].idx == 1 && m[0].cnt == 5) break;
      step("seek_d1c5");
    end
    en = 1'b0;
    run("freeze", 4);
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (m[0].cnt == 7) break;
      step("seek_tc");
    end
    do_load("load_at_tc", 32'h9999, 8'h00);
    run("after_tc", 12);

    // Asynchronous reset away from any clock edge, then release.
    run("pre_rst", 5);
    #3;
    rst_n = 1'b0;
    #1;
    predict();
    compare_all("async_rst");
    run("rst_hold", 2);
    rst_n = 1'b1;
    run("post_rst", 12);

    // Every nibble through the single-digit instance.
    for (int v = 0; v < 16; v++) begin
      do_load("decode_load", {8{4'(v)}}, 8'h00);
      run("decode", 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
